approx_mult_pipe: RTL

- Parametrised, pipelined unsigned WIDTH x WIDTH multiplier with a per-transaction mode bit.
- Mode 0 gives the exact product. Mode 1 gives a truncated-operand approximation: the low TRUNC bits of x are dropped and two fixed AND-term compensation bits are added.
- Valid/ready handshakes on input and output allow the block to sit in streaming datapaths (filters, accumulators) and absorb downstream backpressure without loss.

---
 rtl/approx_mult_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/approx_mult_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier. Each beat is either exact or uses a
// truncated multiplicand with two AND-term compensation bits. Valid/ready is elastic.
module approx_mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int TRUNC  = 10,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z,
    output logic                 out_mode,
    output logic                 busy
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0]  x_hi;
    logic [PW-1:0]     exact_prod;
    logic [PW-1:0]     approx_prod;
    logic [PW-1:0]     comp;
    logic [PW-1:0]     result;
    logic              c_lo;
    logic              c_hi;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] m;
    logic [PW-1:0]     p [STAGES];
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_m;
    logic [PW-1:0]     up_p [STAGES];
    logic              chain;

    // The whole product is formed ahead of stage 0; later stages only carry it.
    always_comb begin
        x_hi        = x >> TRUNC;
        exact_prod  = PW'(x) * PW'(y);
        approx_prod = (PW'(x_hi) * PW'(y)) << TRUNC;
        c_lo        = x[0] & x[1] & y[TRUNC] & y[TRUNC+1];
        c_hi        = x[2] & x[3] & y[TRUNC+3] & y[TRUNC+4];
        comp        = (PW'(c_lo) << (TRUNC + 1)) + (PW'(c_hi) << (TRUNC + 7));
        result      = mode ? (approx_prod + comp) : exact_prod;
    end

    // A stage may load if it, or any stage downstream of it, has room, or the sink takes data.
    always_comb begin
        chain = out_ready;
        load  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain   = chain || !v[k];
            load[k] = chain;
        end
    end

    always_comb begin
        up_v    = '0;
        up_m    = '0;
        for (int k = 0; k < STAGES; k++) begin
            up_p[k] = '0;
        end
        up_v[0] = in_valid;
        up_m[0] = mode;
        up_p[0] = result;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v[k-1];
            up_m[k] = m[k-1];
            up_p[k] = p[k-1];
        end
    end

    // Payload only moves when real data arrives, so z never picks up bubble garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            m <= '0;
            for (int k = 0; k < STAGES; k++) begin
                p[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        p[k] <= up_p[k];
                        m[k] <= up_m[k];
                    end
                end
            end
        end
    end

    assign in_ready  = rst_n && load[0];
    assign out_valid = v[STAGES-1];
    assign z         = p[STAGES-1];
    assign out_mode  = m[STAGES-1];
    assign busy      = |v;

endmodule
